// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status inputs and stage enable/flush controls for the hazard controller
interface pipe_hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [REG_W-1:0] idex_rd;
   logic id_use_rs1;
   logic id_use_rs2;
   logic idex_memread;
   logic exmem_br_taken;
   logic dmem_req;
   logic dmem_ready;
   logic imem_ready;
   logic pc_en;
   logic if_id_en;
   logic id_ex_en;
   logic ex_mem_en;
   logic mem_wb_en;
   logic if_id_flush;
   logic id_ex_flush;
   logic ex_mem_flush;
   logic mem_wb_flush;
   modport master (
      output id_rs1, id_rs2, idex_rd, id_use_rs1, id_use_rs2, idex_memread,
             exmem_br_taken, dmem_req, dmem_ready, imem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
   );
   modport slave (
      input  id_rs1, id_rs2, idex_rd, id_use_rs1, id_use_rs2, idex_memread,
             exmem_br_taken, dmem_req, dmem_ready, imem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush control for the 5-stage pipeline with saturating statistics
module pipe_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   pipe_hazard_ctrl_if.slave hz,
   output logic [1:0]        hz_cause,
   output logic              redirect_pend,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   typedef enum logic [1:0] {HZ_NONE, HZ_MEM, HZ_LU, HZ_FETCH} cause_t;
   logic [REG_W-1:0] rs1, rs2, rd;
   logic mem_wait, load_use, take_br, clear_rp, stall, run;
   cause_t cause_d;
   assign rs1 = hz.id_rs1;
   assign rs2 = hz.id_rs2;
   assign rd = hz.idex_rd;
   assign run = arst_n;
   assign mem_wait = hz.dmem_req & ~hz.dmem_ready;
   // x0 is hardwired, so a load targeting it can never create a dependency
   assign load_use = hz.idex_memread & (rd != '0) &
                     ((hz.id_use_rs1 & (rs1 == rd)) | (hz.id_use_rs2 & (rs2 == rd)));
   assign take_br = ~mem_wait & hz.exmem_br_taken;
   always_comb
      cause_d = mem_wait          ? HZ_MEM   :
                hz.exmem_br_taken ? HZ_NONE  :
                load_use          ? HZ_LU    :
                ~hz.imem_ready    ? HZ_FETCH : HZ_NONE;
   assign stall = cause_d != HZ_NONE;
   assign clear_rp = redirect_pend & ~stall & ~take_br;
   assign hz.pc_en = run & ~stall;
   assign hz.if_id_en = run & ((cause_d == HZ_NONE) | (cause_d == HZ_FETCH));
   assign hz.id_ex_en = run & ~mem_wait;
   assign hz.ex_mem_en = run & ~mem_wait;
   assign hz.mem_wb_en = run;
   assign hz.if_id_flush = run & (take_br | (cause_d == HZ_FETCH) | clear_rp);
   assign hz.id_ex_flush = run & (take_br | (cause_d == HZ_LU));
   assign hz.ex_mem_flush = run & take_br;
   assign hz.mem_wb_flush = run & mem_wait;
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         hz_cause <= '0;
         redirect_pend <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         hz_cause <= cause_d;
         redirect_pend <= (redirect_pend & ~clear_rp) | (take_br & ~hz.imem_ready);
         if (stall & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
         if (take_br & ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
      end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the hazard controller with a rule-level reference model
module tb_pipe_hazard_ctrl;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic [1:0] hz_cause;
   logic redirect_pend;
   logic [CW-1:0] stall_cnt, flush_cnt;
   pipe_hazard_ctrl_if #(.REG_W(5)) hz ();
   pipe_hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
      .clk(clk), .arst_n(arst_n), .hz(hz), .hz_cause(hz_cause),
      .redirect_pend(redirect_pend), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [4:0] en;
      logic [3:0] fl;
      logic [1:0] cause;
      logic rp;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;
   exp_t q[$];
   exp_t me;
   int total = 0, bad = 0;
   int m_rp = 0, m_cause = 0, m_sc = 0, m_fc = 0;
   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask
   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".en"}, {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, e.en);
      chk({tag, ".flush"}, {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush}, e.fl);
      chk({tag, ".hz_cause"}, hz_cause, e.cause);
      chk({tag, ".redirect_pend"}, redirect_pend, e.rp);
      chk({tag, ".stall_cnt"}, stall_cnt, e.sc);
      chk({tag, ".flush_cnt"}, flush_cnt, e.fc);
   endtask
   always @(negedge clk)
      if (q.size() > 0) begin
         me = q.pop_front();
         chk_all("cyc", me);
      end
   task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic mr, input logic [4:0] rd, input logic br, input logic dreq,
                        input logic drdy, input logic irdy);
      int rule;
      exp_t e;
      @(posedge clk);
      #1;
      hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
      hz.idex_memread = mr; hz.idex_rd = rd; hz.exmem_br_taken = br;
      hz.dmem_req = dreq; hz.dmem_ready = drdy; hz.imem_ready = irdy;
      rule = (dreq && !drdy) ? 1 : br ? 2 :
             (mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd))) ? 3 : !irdy ? 4 : 5;
      case (rule)
         1: begin e.en = 5'b00001; e.fl = 4'b0001; end
         2: begin e.en = 5'b11111; e.fl = 4'b1110; end
         3: begin e.en = 5'b00111; e.fl = 4'b0100; end
         4: begin e.en = 5'b01111; e.fl = 4'b1000; end
         default: begin e.en = 5'b11111; e.fl = (m_rp != 0) ? 4'b1000 : 4'b0000; end
      endcase
      e.cause = 2'(m_cause); e.rp = (m_rp != 0); e.sc = CW'(m_sc); e.fc = CW'(m_fc);
      q.push_back(e);
      m_cause = (rule == 1) ? 1 : (rule == 3) ? 2 : (rule == 4) ? 3 : 0;
      if (rule == 2 && !irdy) m_rp = 1;
      else if (rule == 5) m_rp = 0;
      if (rule == 1 || rule == 3 || rule == 4) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
      if (rule == 2) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
   endtask
   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
   endtask
   task automatic set_idle();
      hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
      hz.idex_memread = 0; hz.idex_rd = 0; hz.exmem_br_taken = 0;
      hz.dmem_req = 0; hz.dmem_ready = 1; hz.imem_ready = 1;
   endtask
   task automatic do_reset(input string tag);
      exp_t z;
      @(negedge clk);
      #1;
      set_idle();
      arst_n = 1'b0;
      #1;
      z = '0;
      chk_all(tag, z);
      m_rp = 0; m_cause = 0; m_sc = 0; m_fc = 0;
      @(posedge clk);
      #2;
      arst_n = 1'b1;
   endtask
   initial begin
      exp_t z;
      set_idle();
      #1;
      z = '0;
      chk_all("por", z);
      @(posedge clk);
      #2;
      arst_n = 1'b1;
      cycle(0, 5, 0, 1, 1, 5, 0, 0, 1, 1);
      idle();
      cycle(0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
      idle();
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      idle();
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      idle();
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      idle();
      cycle(3, 7, 1, 1, 1, 3, 1, 1, 0, 1);
      idle();
      repeat (20) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      do_reset("rst_mid_stall");
      idle();
      for (int i = 0; i < 600; i++) begin
         cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) != 0));
         if (i % 97 == 96) do_reset("rst_rand");
      end
      @(negedge clk);
      #1;
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage 64-bit pipeline. It drives the `en` inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also drives per-stage flush strobes, which zero the control fields fed into those registers. It sits beside the pipeline registers, consuming their outputs (ID/EX memread/rd, EX/MEM branch resolution) plus the instruction/data memory ready handshakes, and keeps saturating stall/flush statistics.

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `CNT_W`, 32, width of statistics counters (saturating)

Ports:
- `clk` in 1, single clock, rising edge
- `arst_n` in 1, reset, asynchronous, active-low
- `id_rs1`, `id_rs2` in REG_W, source indices of instruction in ID
- `id_use_rs1`, `id_use_rs2` in 1, ID instruction reads rs1/rs2
- `idex_memread` in 1, ID/EX holds a load
- `idex_rd` in REG_W, destination of ID/EX instruction
- `exmem_br_taken` in 1, EX/MEM branch taken (membranch & zero)
- `dmem_req` in 1, MEM-stage instruction accesses data memory
- `dmem_ready` in 1, data memory completes access this cycle
- `imem_ready` in 1, instruction word valid this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1, register enables
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1, bubble insertion into that register
- `hz_cause` out 2, registered cause of previous cycle: 0 none, 1 mem wait, 2 load-use, 3 fetch wait
- `redirect_pend` out 1, registered discard-next-fetch flag
- `stall_cnt` out CNT_W, cycles with pc_en=0
- `flush_cnt` out CNT_W, taken-branch flush events

## Operation
- Enables/flushes are combinational (Mealy) from inputs and `redirect_pend`; evaluated by strict priority, first match wins:
  1. MEM_WAIT: `dmem_req & ~dmem_ready` -> pc/if_id/id_ex/ex_mem en=0; mem_wb_en=1, mem_wb_flush=1.
  2. BRANCH: `exmem_br_taken` -> all en=1; if_id_flush=id_ex_flush=ex_mem_flush=1; flush_cnt+1. If `imem_ready`=0 the same cycle, set `redirect_pend`.
  3. LOAD_USE: `idex_memread & idex_rd!=0 & ((id_use_rs1 & id_rs1==idex_rd) | (id_use_rs2 & id_rs2==idex_rd))` -> pc_en=0, if_id_en=0, id_ex_flush=1, other en=1.
  4. FETCH_WAIT: `~imem_ready` -> pc_en=0, if_id_flush=1, other en=1.
  5. Otherwise all en=1, all flush=0; if `redirect_pend` and `imem_ready`: if_id_flush=1 (discard stale word), clear `redirect_pend`.
- `redirect_pend`: set only by rule 2; cleared only by rule 5 firing with imem_ready=1; held during rules 1, 3, 4.
- Flush overrides: a register with flush=1 must also have en=1.
- `stall_cnt` increments every cycle pc_en=0 (rules 1, 3, 4); both counters saturate at all-ones, never wrap.
- `hz_cause` registers the rule number (1/3/4 -> 1/2/3); rules 2 and 5 -> 0.
- rd=0 never causes load-use (x0/XZR hardwired).

## Timing
- Zero-cycle latency enable/flush outputs; state (`redirect_pend`, `hz_cause`, counters) updates on rising `clk`.
- Load-use inserts exactly one bubble: the load advances to EX/MEM next cycle, so the condition self-clears.
- MEM_WAIT persists N cycles for N cycles of `dmem_ready`=0; on the ready cycle, rule 1 is false and the pipeline advances.
- Taken-branch penalty: 3 bubbles, plus one more discarded fetch if redirect was pending.
- While `arst_n`=0: all en=0, all flush=0, `redirect_pend`=0, `hz_cause`=0, counters=0, asynchronously. First cycle after deassert evaluates rules normally.
- Reset mid-stall drops pending state; no flush issued at release.

## Test plan
- Load-use: idex_memread=1, idex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1, hz_cause=2 next cycle; idex_rd=0 with same rs -> no stall.
- Data wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles of all-upstream en=0 and mem_wb_flush=1; stall_cnt=3; advance on 4th.
- Branch: exmem_br_taken=1, imem_ready=1 -> three flushes same cycle, flush_cnt=1, redirect_pend stays 0.
- Redirect: br_taken with imem_ready=0, then imem_ready=0 for 2 cycles, then 1 -> redirect_pend=1 for 3 cycles; if_id_flush=1 on the ready cycle; cleared after.
- Priority: dmem stall, br_taken and load-use all asserted together -> MEM_WAIT outputs only, flush_cnt unchanged.
- Saturation/reset: CNT_W=4, 20 stall cycles -> stall_cnt=15; assert arst_n=0 mid-stall -> all outputs 0 immediately.
